// File: rtl/voice_mix_pkg.sv
// Shared types, default sizes and accumulator sizing for the voice event mixer.
package voice_mix_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    CLOSE   = 1'b1
  } mix_state_t;

  localparam int NUM_VOICES_DEF = 37;
  localparam int SAMPLE_W_DEF   = 16;
  localparam int IDX_W          = 6;

  // One sign bit of headroom per doubling of the voice count keeps a full frame exact.
  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Decodes the per-voice strobe vector into a slot index plus exactly-one / more-than-one flags.
module onehot_to_index
  import voice_mix_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF
) (
  input  logic [NUM_VOICES-1:0] events,
  output logic [IDX_W-1:0]      index,
  output logic                  valid,
  output logic                  multi
);

  logic [NUM_VOICES-1:0] low_cleared;

  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  always_comb begin
    low_cleared = events & (events - {{(NUM_VOICES-1){1'b0}}, 1'b1});
    multi       = (low_cleared != {NUM_VOICES{1'b0}});
    valid       = (events != {NUM_VOICES{1'b0}}) && !multi;
    index       = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      index = index | (events[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

endmodule

// File: rtl/voice_event_mixer.sv
// Sums one sample per voice slot into a frame, then saturates and hands it downstream.
// Optional feature macro: VOICE_MIX_CLIP_STATS_EN enables the saturated-frame counter.
module voice_event_mixer
  import voice_mix_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_VOICES-1:0]      events,
  input  logic signed [SAMPLE_W-1:0] voice_sample,
  input  logic                       mix_ready,
  output logic signed [SAMPLE_W-1:0] mix_sample,
  output logic                       mix_valid,
  output logic                       frame_err,
  output logic                       overrun,
  output logic [15:0]                clip_count
);

  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  mix_state_t                  state;
  logic signed [ACC_W-1:0]     acc;
  logic [NUM_VOICES-1:0]       seen;
  logic [IDX_W-1:0]            strobe_idx;
  logic                        strobe_valid;
  logic                        strobe_multi;
  logic                        strobe_last;
  logic signed [ACC_W-1:0]     sample_ext;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [SAMPLE_W-1:0]  sat_val;

  onehot_to_index #(
    .NUM_VOICES(NUM_VOICES)
  ) u_onehot_to_index (
    .events(events),
    .index (strobe_idx),
    .valid (strobe_valid),
    .multi (strobe_multi)
  );

  // Sign extension, gain shift and output saturation of the running frame sum.
  always_comb begin
    sample_ext  = {{(ACC_W-SAMPLE_W){voice_sample[SAMPLE_W-1]}}, voice_sample};
    strobe_last = strobe_valid && (strobe_idx == IDX_W'(NUM_VOICES-1));
    shifted     = acc >>> GAIN_SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[SAMPLE_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_val = shifted[SAMPLE_W-1:0];
    end
  end

  // Frame FSM, accumulator and the registered output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      acc        <= {ACC_W{1'b0}};
      seen       <= {NUM_VOICES{1'b0}};
      mix_sample <= {SAMPLE_W{1'b0}};
      mix_valid  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (strobe_multi) begin
        frame_err <= 1'b1;
      end
      if (mix_valid && mix_ready) begin
        mix_valid <= 1'b0;
      end
      case (state)
        COLLECT: begin
          if (strobe_valid) begin
            acc  <= acc + sample_ext;
            seen <= seen | events;
            if (strobe_last) begin
              state <= CLOSE;
            end
          end
        end
        CLOSE: begin
          // A frame always closes and is presented, even when some slots never arrived.
          if (seen != {NUM_VOICES{1'b1}}) begin
            frame_err <= 1'b1;
          end
          if (mix_valid && !mix_ready) begin
            overrun <= 1'b1;
          end
          mix_sample <= sat_val;
          mix_valid  <= 1'b1;
          if (strobe_valid) begin
            acc   <= sample_ext;
            seen  <= events;
            state <= strobe_last ? CLOSE : COLLECT;
          end else begin
            acc   <= {ACC_W{1'b0}};
            seen  <= {NUM_VOICES{1'b0}};
            state <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

`ifdef VOICE_MIX_CLIP_STATS_EN
  logic clipped;
  logic [15:0] clip_cnt;

  assign clipped    = (shifted > SAT_MAX) || (shifted < SAT_MIN);
  assign clip_count = clip_cnt;

  // Saturating count of frames whose value was altered by clipping.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt <= 16'h0000;
    end else if ((state == CLOSE) && clipped && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'h0001;
    end
  end
`else
  assign clip_count = 16'h0000;
`endif

endmodule

// File: tb/tb_voice_event_mixer.sv
// Randomized and directed self-checking bench for voice_event_mixer against a frame-level model.
module tb_voice_event_mixer;

  localparam int NV = 37;
  localparam int SW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NV-1:0]        events;
  logic signed [SW-1:0] voice_sample;
  logic                 mix_ready;
  logic signed [SW-1:0] mix_sample;
  logic                 mix_valid;
  logic                 frame_err;
  logic                 overrun;
  logic [15:0]          clip_count;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  err_m;
  bit  ov_m;
  int  clip_m;
  bit  pending;
  int  fv[NV];
  bit  fi[NV];

  voice_event_mixer dut (
    .clk         (clk),
    .rst         (rst),
    .events      (events),
    .voice_sample(voice_sample),
    .mix_ready   (mix_ready),
    .mix_sample  (mix_sample),
    .mix_valid   (mix_valid),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .clip_count  (clip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clip_exp();
`ifdef VOICE_MIX_CLIP_STATS_EN
    return (clip_m > 65535) ? 65535 : clip_m;
`else
    return 0;
`endif
  endfunction

  // An output still waiting is taken by the first edge that sees ready high.
  task automatic tick();
    if (mix_ready) pending = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [NV-1:0] ev, input int val);
    events       = ev;
    voice_sample = 16'(val);
    tick();
    events       = '0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    events = '0;
    tick();
    tick();
    rst     = 1'b0;
    err_m   = 1'b0;
    ov_m    = 1'b0;
    clip_m  = 0;
    pending = 1'b0;
  endtask

  task automatic fill(input int val);
    for (int s = 0; s < NV; s++) begin
      fv[s] = val;
      fi[s] = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input int first, input longint carry,
                           input int max_gap, input bit do_multi, input logic [NV-1:0] multi_ev,
                           input int rdy_close, input bit seed, input int seed_val);
    longint        sum;
    longint        exp_s;
    bit            all;
    logic [NV-1:0] ev;
    int            b1;
    sum = carry;
    all = 1'b1;
    for (int s = first; s < NV; s++) begin
      if (do_multi && s == 10) begin
        ev = multi_ev;
        if (ev == '0) begin
          b1 = $urandom_range(0, NV - 1);
          ev[b1] = 1'b1;
          ev[(b1 + 1 + $urandom_range(0, NV - 2)) % NV] = 1'b1;
        end
        strobe(ev, int'($urandom_range(0, 65535)));
        err_m = 1'b1;
      end
      if (fi[s]) begin
        ev = '0;
        ev[s] = 1'b1;
        strobe(ev, fv[s]);
        sum += fv[s];
      end else begin
        all = 1'b0;
      end
      if (s < NV - 1) repeat ($urandom_range(0, max_gap)) tick();
    end
    chk({tag, "_latency_valid"}, mix_valid, pending);
    if (rdy_close >= 0) mix_ready = rdy_close[0];
    if (pending && !mix_ready) ov_m = 1'b1;
    if (!all) err_m = 1'b1;
    if (sum > 32767 || sum < -32768) clip_m++;
    exp_s = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
    if (seed) strobe({{(NV-1){1'b0}}, 1'b1}, seed_val);
    else tick();
    pending = 1'b1;
    chk({tag, "_valid"}, mix_valid, 1);
    chk({tag, "_sample"}, mix_sample, exp_s);
    chk({tag, "_frame_err"}, frame_err, err_m);
    chk({tag, "_overrun"}, overrun, ov_m);
    chk({tag, "_clip_count"}, clip_count, clip_exp());
  endtask

  initial begin
    logic signed [15:0] r;
    rst          = 1'b1;
    events       = '0;
    voice_sample = '0;
    mix_ready    = 1'b1;
    do_reset();
    chk("rst_sample", mix_sample, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_clip", clip_count, 0);

    fill(100);
    run_frame("sum100", 0, 0, 0, 1'b0, '0, -1, 1'b0, 0);
    tick();
    chk("sum100_drop", mix_valid, 0);

    fill(32767);
    run_frame("satpos", 0, 0, 1, 1'b0, '0, -1, 1'b0, 0);
    fill(-32768);
    run_frame("satneg", 0, 0, 1, 1'b0, '0, -1, 1'b0, 0);

    fill(1);
    run_frame("seed_a", 0, 0, 0, 1'b0, '0, -1, 1'b1, -500);
    fill(2);
    run_frame("seed_b", 1, -500, 0, 1'b0, '0, -1, 1'b0, 0);

    mix_ready = 1'b0;
    fill(7);
    run_frame("hs_a", 0, 0, 0, 1'b0, '0, -1, 1'b0, 0);
    fill(-9);
    run_frame("hs_b", 0, 0, 0, 1'b0, '0, 1, 1'b0, 0);
    tick();
    chk("hs_drop", mix_valid, 0);

    mix_ready = 1'b0;
    fill(11);
    run_frame("ovr_a", 0, 0, 0, 1'b0, '0, -1, 1'b0, 0);
    fill(-23);
    run_frame("ovr_b", 0, 0, 0, 1'b0, '0, -1, 1'b0, 0);
    mix_ready = 1'b1;
    tick();

    fill(300);
    run_frame("multi", 0, 0, 0, 1'b1, {{(NV-2){1'b0}}, 2'b11}, -1, 1'b0, 0);

    do_reset();
    for (int s = 0; s < 10; s++) strobe(NV'(1) << s, 1000);
    do_reset();
    fill(50);
    run_frame("after_rst", 0, 0, 0, 1'b0, '0, -1, 1'b0, 0);
    fill(40);
    fi[5] = 1'b0;
    run_frame("slot5_miss", 0, 0, 0, 1'b0, '0, -1, 1'b0, 0);

    do_reset();
    for (int f = 0; f < 12; f++) begin
      for (int s = 0; s < NV; s++) begin
        r     = 16'($urandom);
        fv[s] = (f % 3 == 0) ? int'(r) : int'(r) / 64;
        fi[s] = (s == NV - 1) ? 1'b1 : ($urandom_range(0, 99) >= 2);
      end
      mix_ready = ($urandom_range(0, 3) != 0);
      run_frame("rand", 0, 0, 2, ($urandom_range(0, 9) == 0), '0, -1, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
